// File: rtl/spi_dut_bridge_pkg.sv
// Shared encodings for the SPI-to-DUT command bridge: commands, FSM states, CONTROL flag positions.
package spi_dut_bridge_pkg;
   localparam int CMD_STATUS  = 0;
   localparam int CMD_CONTROL = 1;
   localparam int CMD_WRITE   = 2;
   localparam int CMD_READ    = 3;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_DECODE     = 3'd1;
   localparam logic [2:0] S_WRITE      = 3'd2;
   localparam logic [2:0] S_READ_WAIT  = 3'd3;
   localparam logic [2:0] S_READ_LATCH = 3'd4;
   localparam logic [2:0] S_RUN        = 3'd5;

   // CONTROL flags are counted down from the data MSB
   localparam int CTRL_START_OFS    = 0;
   localparam int CTRL_LED_OFS      = 1;
   localparam int CTRL_AUTO_INC_OFS = 2;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction
endpackage

// File: rtl/test_watchdog.sv
// Test-run watchdog: down-counter loaded at test start, expires on its terminal count while enabled.
module test_watchdog
   import spi_dut_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_cnt
         localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (load)
               cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
            else if (en && (cnt_q != '0))
               cnt_d = cnt_q - CNT_W'(1);
         end

         always_ff @(posedge clk_sys or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
         end

         assign expire = en && (cnt_q == '0);
      end else begin : g_off
         logic unused_tie;
         assign unused_tie = ^{clk_sys, rst, load, en};
         assign expire     = 1'b0;
      end
   endgenerate
endmodule

// File: rtl/spi_dut_bridge.sv
// Decodes SPI command words into DUT register accesses, test starts and LED control;
// one response word is produced per transaction.
//
// state        | meaning
// S_IDLE       | waiting for a word edge
// S_DECODE     | captured word is decoded, response/DUT drive computed
// S_WRITE      | one-cycle write strobe
// S_READ_WAIT  | DUT_ADR/DUT_RnW held for the read latency
// S_READ_LATCH | DUT_DOUT latched into the response
// S_RUN        | test running, watchdog active
module spi_dut_bridge
   import spi_dut_bridge_pkg::*;
#(
   parameter int BITWIDTH       = 24,
   parameter int BITWIDTH_CMDS  = 2,
   parameter int BITWIDTH_ADR   = 6,
   parameter int BITWIDTH_DATA  = 16,
   parameter int BITWIDTH_HEAD  = 32,
   parameter int NUM_DUT        = 5,
   parameter int READ_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                         CLK_SYS,
   input  logic                         RST,
   input  logic                         FIFO_RDY,
   input  logic [BITWIDTH-1:0]          FIFO_DIN,
   output logic [BITWIDTH-1:0]          FIFO_DOUT,
   output logic                         LED_CONTROL,
   output logic                         DUT_DO_TEST,
   output logic [$clog2(NUM_DUT):0]     DUT_SEL,
   output logic [BITWIDTH_ADR-1:0]      DUT_ADR,
   output logic                         DUT_RnW,
   output logic                         DUT_WR_EN,
   output logic [BITWIDTH_DATA-1:0]     DUT_DIN,
   input  logic [BITWIDTH_DATA-1:0]     DUT_DOUT,
   input  logic [BITWIDTH_HEAD-1:0]     DUT_HEADER,
   input  logic                         DUT_RDY,
   output logic                         BUSY,
   output logic                         ERR
);
   localparam int CMD_W = BITWIDTH_CMDS;
   localparam int AW    = BITWIDTH_ADR;
   localparam int DW    = BITWIDTH_DATA;
   localparam int SEL_W = $clog2(NUM_DUT) + 1;
   localparam int NCH   = ceil_div(BITWIDTH_HEAD, DW);
   localparam int HPW   = NCH * DW;
   localparam int PAD_W = DW - 6 - SEL_W;
   localparam int LAT_W = 4;

   logic                rdy_q, rdy_d, rdy_d1_q, rdy_d1_d;
   logic [2:0]          state_q, state_d;
   logic [BITWIDTH-1:0] word_q, word_d, fifo_dout_q, fifo_dout_d;
   logic [AW-1:0]       ptr_q, ptr_d, dut_adr_q, dut_adr_d;
   logic                auto_inc_q, auto_inc_d, led_q, led_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                timeout_q, timeout_d, err_busy_q, err_busy_d;
   logic                do_test_q, do_test_d, rnw_q, rnw_d, wr_en_q, wr_en_d;
   logic [DW-1:0]       din_q, din_d;
   logic [LAT_W-1:0]    lat_q, lat_d;

   logic                word_edge, wd_load, wd_expire;
   logic [CMD_W-1:0]    w_cmd, f_cmd;
   logic [AW-1:0]       w_adr, f_adr, stat_adr, eff_adr;
   logic [DW-1:0]       w_data, stat_data;
   logic [HPW-1:0]      head_pad, head_shift;

   assign word_edge = rdy_q & ~rdy_d1_q;
   assign w_cmd     = word_q[BITWIDTH-1 -: CMD_W];
   assign w_adr     = word_q[DW +: AW];
   assign w_data    = word_q[DW-1:0];
   assign f_cmd     = FIFO_DIN[BITWIDTH-1 -: CMD_W];
   assign f_adr     = FIFO_DIN[DW +: AW];
   assign eff_adr   = auto_inc_q ? ptr_q : w_adr;
   assign head_pad  = HPW'(DUT_HEADER);
   // STATUS words arriving during RUN are served straight from the FIFO word
   assign stat_adr  = (state_q == S_RUN) ? f_adr : w_adr;

   always_comb begin
      head_shift = '0;
      stat_data  = '0;
      if (stat_adr == '0) begin
         stat_data = {timeout_q, err_busy_q, state_q == S_RUN, DUT_RDY, auto_inc_q, led_q,
                      {PAD_W{1'b0}}, sel_q};
      end else if (int'(stat_adr) <= NCH) begin
         head_shift = head_pad >> ((int'(stat_adr) - 1) * DW);
         stat_data  = head_shift[DW-1:0];
      end
   end

   test_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk_sys (CLK_SYS),
      .rst     (RST),
      .load    (wd_load),
      .en      (state_q == S_RUN),
      .expire  (wd_expire)
   );

   always_comb begin
      rdy_d       = FIFO_RDY;
      rdy_d1_d    = rdy_q;
      state_d     = state_q;
      word_d      = word_q;
      fifo_dout_d = fifo_dout_q;
      ptr_d       = ptr_q;
      dut_adr_d   = dut_adr_q;
      auto_inc_d  = auto_inc_q;
      led_d       = led_q;
      sel_d       = sel_q;
      timeout_d   = timeout_q;
      err_busy_d  = err_busy_q;
      do_test_d   = 1'b0;
      rnw_d       = rnw_q;
      wr_en_d     = 1'b0;
      din_d       = din_q;
      lat_d       = lat_q;
      wd_load     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (word_edge) begin
               word_d  = FIFO_DIN;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_IDLE;
            case (w_cmd)
               CMD_W'(CMD_STATUS): begin
                  fifo_dout_d = {w_cmd, w_adr, stat_data};
                  if (w_adr == '0) begin
                     timeout_d  = 1'b0;
                     err_busy_d = 1'b0;
                  end
               end
               CMD_W'(CMD_CONTROL): begin
                  fifo_dout_d = {w_cmd, w_adr, w_data};
                  led_d       = w_data[DW-1-CTRL_LED_OFS];
                  auto_inc_d  = w_data[DW-1-CTRL_AUTO_INC_OFS];
                  ptr_d       = w_adr;
                  if (w_data[SEL_W-1:0] < SEL_W'(NUM_DUT)) sel_d = w_data[SEL_W-1:0];
                  else                                     err_busy_d = 1'b1;
                  if (w_data[DW-1-CTRL_START_OFS]) begin
                     do_test_d = 1'b1;
                     wd_load   = 1'b1;
                     state_d   = S_RUN;
                  end
               end
               CMD_W'(CMD_WRITE): begin
                  fifo_dout_d = {w_cmd, eff_adr, w_data};
                  dut_adr_d   = eff_adr;
                  din_d       = w_data;
                  rnw_d       = 1'b0;
                  wr_en_d     = 1'b1;
                  if (auto_inc_q) ptr_d = ptr_q + AW'(1);
                  state_d     = S_WRITE;
               end
               default: begin
                  dut_adr_d = eff_adr;
                  rnw_d     = 1'b1;
                  if (auto_inc_q) ptr_d = ptr_q + AW'(1);
                  if (READ_LATENCY == 0) begin
                     state_d = S_READ_LATCH;
                  end else begin
                     lat_d   = LAT_W'(READ_LATENCY - 1);
                     state_d = S_READ_WAIT;
                  end
               end
            endcase
         end
         S_WRITE: begin
            rnw_d   = 1'b1;
            state_d = S_IDLE;
         end
         S_READ_WAIT: begin
            if (lat_q == '0) state_d = S_READ_LATCH;
            else             lat_d   = lat_q - LAT_W'(1);
         end
         S_READ_LATCH: begin
            fifo_dout_d = {CMD_W'(CMD_READ), dut_adr_q, DUT_DOUT};
            state_d     = S_IDLE;
         end
         S_RUN: begin
            if (word_edge) begin
               if (f_cmd == CMD_W'(CMD_STATUS)) begin
                  fifo_dout_d = {f_cmd, f_adr, stat_data};
                  if (f_adr == '0) begin
                     timeout_d  = 1'b0;
                     err_busy_d = 1'b0;
                  end
               end else begin
                  err_busy_d = 1'b1;
               end
            end
            // DUT_RDY is ignored in the first RUN cycle, flagged by the start pulse
            if (!do_test_q && DUT_RDY) begin
               state_d = S_IDLE;
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (word_edge && (state_q != S_IDLE) && (state_q != S_RUN))
         err_busy_d = 1'b1;
   end

   always_ff @(posedge CLK_SYS or posedge RST) begin
      if (RST) begin
         rdy_q       <= 1'b0;
         rdy_d1_q    <= 1'b0;
         state_q     <= S_IDLE;
         word_q      <= '0;
         fifo_dout_q <= '0;
         ptr_q       <= '0;
         dut_adr_q   <= '0;
         auto_inc_q  <= 1'b0;
         led_q       <= 1'b0;
         sel_q       <= '0;
         timeout_q   <= 1'b0;
         err_busy_q  <= 1'b0;
         do_test_q   <= 1'b0;
         rnw_q       <= 1'b1;
         wr_en_q     <= 1'b0;
         din_q       <= '0;
         lat_q       <= '0;
      end else begin
         rdy_q       <= rdy_d;
         rdy_d1_q    <= rdy_d1_d;
         state_q     <= state_d;
         word_q      <= word_d;
         fifo_dout_q <= fifo_dout_d;
         ptr_q       <= ptr_d;
         dut_adr_q   <= dut_adr_d;
         auto_inc_q  <= auto_inc_d;
         led_q       <= led_d;
         sel_q       <= sel_d;
         timeout_q   <= timeout_d;
         err_busy_q  <= err_busy_d;
         do_test_q   <= do_test_d;
         rnw_q       <= rnw_d;
         wr_en_q     <= wr_en_d;
         din_q       <= din_d;
         lat_q       <= lat_d;
      end
   end

   assign FIFO_DOUT   = fifo_dout_q;
   assign LED_CONTROL = led_q;
   assign DUT_DO_TEST = do_test_q;
   assign DUT_SEL     = sel_q;
   assign DUT_ADR     = dut_adr_q;
   assign DUT_RnW     = rnw_q;
   assign DUT_WR_EN   = wr_en_q;
   assign DUT_DIN     = din_q;
   assign BUSY        = (state_q != S_IDLE);
   assign ERR         = timeout_q | err_busy_q;
endmodule

// File: doc/spi_dut_bridge.md
# spi_dut_bridge

Parametrised command bridge between the word-oriented SPI slave and the DUT test environment, replacing the fixed middleware. It decodes fixed-width SPI command words into DUT register reads and writes, test starts and LED control, and returns one response word per transaction. New behaviour compared with the fixed middleware:
- auto-increment address pointer;
- configurable DUT read latency;
- chunked header readout for any header width;
- test-run watchdog with sticky error flags.

## Interface
Parameters:
- BITWIDTH, 24: SPI word width; must equal BITWIDTH_CMDS + BITWIDTH_ADR + BITWIDTH_DATA.
- BITWIDTH_CMDS, 2: command field width.
- BITWIDTH_ADR, 6: DUT address width.
- BITWIDTH_DATA, 16: DUT data width.
- BITWIDTH_HEAD, 32: DUT header width; read in ceil(BITWIDTH_HEAD/BITWIDTH_DATA) chunks.
- NUM_DUT, 5: number of selectable DUTs; SEL_W = $clog2(NUM_DUT)+1.
- READ_LATENCY, 1: cycles from DUT_RnW=1 and DUT_ADR valid until DUT_DOUT is valid; range 0..15.
- TIMEOUT_CYCLES, 1_000_000: maximum test-run length; 0 disables the watchdog.

Ports:
- CLK_SYS  in  1  system clock.
- RST  in  1  reset; one clock; asynchronous, active-high.
- FIFO_RDY  in  1  SPI slave word-ready level; a rising edge marks FIFO_DIN valid.
- FIFO_DIN  in  BITWIDTH  received word, {cmd, adr, data}.
- FIFO_DOUT  out  BITWIDTH  response word shifted out in the next transaction.
- LED_CONTROL  out  1  host-controlled LED.
- DUT_DO_TEST  out  1  one-cycle test start pulse.
- DUT_SEL  out  SEL_W  selected DUT.
- DUT_ADR  out  BITWIDTH_ADR  register address.
- DUT_RnW  out  1  1 = read, 0 = write.
- DUT_WR_EN  out  1  one-cycle write strobe.
- DUT_DIN  out  BITWIDTH_DATA  write data.
- DUT_DOUT  in  BITWIDTH_DATA  read data.
- DUT_HEADER  in  BITWIDTH_HEAD  DUT identification header.
- DUT_RDY  in  1  DUT finished (high = idle/done).
- BUSY  out  1  high whenever the FSM is not in IDLE.
- ERR  out  1  OR of the sticky flags TIMEOUT and ERR_BUSY.

## Operation
- **Word-ready detection:** FIFO_RDY is registered once; the word is captured on the cycle after a rising edge.
- **Command 0, STATUS:** the adr field selects the response.
  - adr 0: status word {TIMEOUT, ERR_BUSY, RUNNING, DUT_RDY, AUTO_INC, LED, zero pad, DUT_SEL}.
  - adr k≥1: header chunk k-1, LSB chunk first, zero-padded.
  - An adr-0 STATUS clears TIMEOUT and ERR_BUSY after the status word has been latched.
- **Command 1, CONTROL:**
  - data[MSB] = START: pulses DUT_DO_TEST and enters RUN.
  - data[MSB-1] = LED.
  - data[MSB-2] = AUTO_INC.
  - data[SEL_W-1:0] = DUT_SEL.
  - adr loads the address pointer.
  - A DUT_SEL value ≥ NUM_DUT is ignored; the old value is kept and ERR_BUSY is set.
- **Command 2, WRITE:** drives DUT_ADR (the pointer when AUTO_INC=1, otherwise adr) and DUT_DIN = data, DUT_RnW=0, DUT_WR_EN=1 for one cycle.
- **Command 3, READ:** holds DUT_RnW=1 and DUT_ADR for READ_LATENCY cycles, then latches DUT_DOUT into the response.
- **Auto-increment:** with AUTO_INC=1, the pointer post-increments after each WRITE or READ and wraps from 2^BITWIDTH_ADR-1 to 0.
- **Response word:** {cmd, effective adr, data}; FIFO_DOUT is held until the next response is produced.
- **FSM states:** IDLE, DECODE, WRITE, READ_WAIT, READ_LATCH, RUN.
  - IDLE→DECODE on a word edge.
  - DECODE→WRITE, READ_WAIT, RUN (CONTROL with START) or IDLE.
  - WRITE→IDLE.
  - READ_WAIT→READ_LATCH after READ_LATENCY cycles (direct when 0).
  - READ_LATCH→IDLE.
  - RUN→IDLE on DUT_RDY=1, sampled from the second RUN cycle onward, or on watchdog expiry (sets TIMEOUT).
- **Words arriving in RUN:** STATUS is served; any other command is dropped and sets ERR_BUSY.
- **Words arriving in WRITE, READ_WAIT or READ_LATCH:** not possible at legal SPI rates; such a word is dropped and sets ERR_BUSY.
- **Reset values:** FIFO_DOUT=0, LED_CONTROL=0, DUT_DO_TEST=0, DUT_SEL=0, DUT_ADR=0, DUT_RnW=1, DUT_WR_EN=0, DUT_DIN=0, BUSY=0, ERR=0; pointer=0, AUTO_INC=0, flags=0, state IDLE.
- **Reset mid-operation:** reset asserted during RUN or a read aborts immediately and returns all outputs to their reset values.

## Timing
- FIFO_RDY rising edge at cycle n: decode at n+2.
- WRITE strobe at n+3; write response valid at n+3.
- READ response valid at n+4+READ_LATENCY.
- CONTROL: DUT_DO_TEST pulse at n+3; BUSY high from n+2 until DUT_RDY is seen high.
- Watchdog counts RUN cycles; expiry at exactly TIMEOUT_CYCLES cycles in RUN.
- Throughput: one word per 4+READ_LATENCY cycles, well below the SPI word rate.

## Structure
- **Package spi_dut_bridge_pkg:** command encodings (CMD_STATUS=0, CMD_CONTROL=1, CMD_WRITE=2, CMD_READ=3), the state enum, and the CONTROL bit positions.
- **Sub-module test_watchdog:** load/enable/expire counter of width $clog2(TIMEOUT_CYCLES+1); tied off when TIMEOUT_CYCLES=0.

## Test plan
- WRITE 0x2_05_ABCD → DUT_ADR=5, DUT_DIN=0xABCD, DUT_WR_EN one cycle, DUT_RnW=0 during the strobe; FIFO_DOUT=0x85ABCD.
- READ adr 9 with READ_LATENCY=3 and DUT_DOUT=0x1234 → FIFO_DOUT=0xC91234, valid at n+7.
- CONTROL with AUTO_INC=1, adr 62, followed by four READs → effective addresses 62, 63, 0, 1.
- CONTROL with START, DUT_SEL=2, and DUT_RDY low for 100 cycles (TIMEOUT_CYCLES=1000) → one DUT_DO_TEST pulse, DUT_SEL=2, BUSY for 101 cycles, ERR=0.
- DUT_RDY held low with TIMEOUT_CYCLES=50; a WRITE arrives during RUN → write dropped, ERR_BUSY=1; TIMEOUT=1 at 50 cycles; STATUS adr 0 returns both flags set, then ERR=0.
- RST asserted in READ_WAIT; STATUS adr 1 and adr 2 with DUT_HEADER=0xDEADBEEF → all outputs at reset values; then responses carry 0xBEEF and 0xDEAD.
